// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I opcode constants and hazard controller state type
package rv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} hazard_state_t;
endpackage

// File: rtl/reg_use_decode.sv
// reg_use_decode: extracts source register fields and whether the opcode reads them
module reg_use_decode import rv_pkg::*; (
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        uses_rs1,
  output logic        uses_rs2
);
  logic [6:0] op;
  logic       unused_bits;
  assign op          = instr[6:0];
  assign rs1         = instr[19:15];
  assign rs2         = instr[24:20];
  assign unused_bits = ^{instr[31:25], instr[14:7]};
  assign uses_rs1    = op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  assign uses_rs2    = op inside {OP_R, OP_STORE, OP_BRANCH};
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stalls, redirect flushes and memory freeze with timeout watchdog
module hazard_ctrl import rv_pkg::*; #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_id_instr,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             pc_sel_redirect,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  hazard_state_t state;
  logic [7:0]    wait_cnt;
  logic [4:0]    rs1, rs2;
  logic          uses_rs1, uses_rs2;
  logic          freeze, load_use, active, redirect_act, stall_cyc;

  reg_use_decode u_dec (
    .instr    (if_id_instr),
    .rs1      (rs1),
    .rs2      (rs2),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign freeze       = dmem_req && !dmem_ready;
  assign load_use     = id_ex_mem_read && id_ex_rd != 5'd0 &&
                        ((uses_rs1 && rs1 == id_ex_rd) || (uses_rs2 && rs2 == id_ex_rd));
  assign active       = state != ERROR;
  assign redirect_act = active && !freeze && ex_redirect;
  assign stall_cyc    = active && (freeze || (load_use && !ex_redirect));

  // pipeline control decision: reset NOPs, then freeze > redirect > load-use > run
  always_comb begin
    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
    pc_sel_redirect = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_bubble    = 1'b0;
    if (!rst_n) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (!active || freeze) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
    end else if (ex_redirect) begin
      pc_sel_redirect = 1'b1;
      if_id_flush     = 1'b1;
      id_ex_bubble    = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // freeze watchdog: count consecutive frozen cycles, lock into ERROR on timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        RUN: if (freeze) begin
          state    <= MEM_WAIT;
          wait_cnt <= 8'd1;
        end
        MEM_WAIT: if (!freeze) begin
          state    <= RUN;
          wait_cnt <= '0;
        end else if (wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
          state   <= ERROR;
          mem_err <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
        default: mem_err <= 1'b1;
      endcase
    end
  end

  // saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_cyc && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
      if (redirect_act && !(&flush_count)) flush_count <= flush_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stalls, flushes, freeze, timeout and saturation
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_id_instr;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rd;
  logic        ex_redirect, dmem_req, dmem_ready;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        pc_sel_redirect, if_id_flush, id_ex_bubble, mem_err;
  logic [3:0]  stall_count, flush_count;
  logic [7:0]  outs;
  int          total = 0;
  int          bad = 0;

  localparam logic [7:0] O_RUN = 8'hF8, O_FRZ = 8'h00, O_RDR = 8'hFF, O_LU = 8'h39, O_RST = 8'h03;
  localparam logic [31:0] ADD_X6_X5_X7 = 32'h00728333, ADD_X6_X0_X0 = 32'h00000333,
                          LUI_X5 = 32'h000282B7, SW_X5 = 32'h00532023, JAL_F = 32'h0002806F;

  assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pc_sel_redirect, if_id_flush, id_ex_bubble};

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .if_id_instr(if_id_instr), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rd(id_ex_rd), .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .pc_sel_redirect(pc_sel_redirect), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .mem_err(mem_err), .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic mr, input logic [4:0] rd,
                       input logic rdr, input logic req, input logic rdy);
    if_id_instr = ins; id_ex_mem_read = mr; id_ex_rd = rd;
    ex_redirect = rdr; dmem_req = req; dmem_ready = rdy;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(ADD_X6_X5_X7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("reset_outs", 32'(outs), 32'(O_RST));
    chk("reset_stall", 32'(stall_count), 0);
    chk("reset_flush", 32'(flush_count), 0);
    chk("reset_err", 32'(mem_err), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("lu_rs1_outs", 32'(outs), 32'(O_LU));
    tick();
    drive(ADD_X6_X5_X7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("lu_after_outs", 32'(outs), 32'(O_RUN));
    chk("lu_stall_cnt", 32'(stall_count), 1);
    drive(ADD_X6_X0_X0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("lu_x0_outs", 32'(outs), 32'(O_RUN));
    drive(LUI_X5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("lu_lui_outs", 32'(outs), 32'(O_RUN));
    drive(JAL_F, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("lu_jal_outs", 32'(outs), 32'(O_RUN));
    tick();
    chk("no_stall_cnt", 32'(stall_count), 1);
    drive(SW_X5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("lu_rs2_outs", 32'(outs), 32'(O_LU));
    tick();
    chk("lu_rs2_cnt", 32'(stall_count), 2);
    drive(ADD_X6_X5_X7, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("rdr_lu_outs", 32'(outs), 32'(O_RDR));
    tick();
    chk("rdr_flush_cnt", 32'(flush_count), 1);
    chk("rdr_stall_cnt", 32'(stall_count), 2);
    drive(ADD_X6_X0_X0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("freeze_outs%0d", i), 32'(outs), 32'(O_FRZ));
      tick();
    end
    drive(ADD_X6_X0_X0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    chk("freeze_end_outs", 32'(outs), 32'(O_RDR));
    tick();
    chk("freeze_stall_cnt", 32'(stall_count), 5);
    chk("freeze_flush_cnt", 32'(flush_count), 2);
    chk("freeze_err", 32'(mem_err), 0);
    drive(ADD_X6_X0_X0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("same_cycle_hs_outs", 32'(outs), 32'(O_RUN));
    tick();
    chk("same_cycle_hs_cnt", 32'(stall_count), 5);
    drive(ADD_X6_X0_X0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("run_after_wait", 32'(outs), 32'(O_FRZ));
    drive(ADD_X6_X5_X7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_reach", 32'(stall_count), 15);
    tick();
    chk("sat_hold", 32'(stall_count), 15);
    chk("sat_outs", 32'(outs), 32'(O_LU));
    drive(ADD_X6_X0_X0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_frozen%0d", i), 32'(outs), 32'(O_FRZ));
      chk($sformatf("to_noerr%0d", i), 32'(mem_err), 0);
      tick();
    end
    chk("to_err", 32'(mem_err), 1);
    drive(ADD_X6_X0_X0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    chk("err_outs", 32'(outs), 32'(O_FRZ));
    tick();
    chk("err_sticky", 32'(mem_err), 1);
    chk("err_flush_cnt", 32'(flush_count), 2);
    rst_n = 1'b0;
    #1;
    chk("areset_outs", 32'(outs), 32'(O_RST));
    chk("areset_err", 32'(mem_err), 0);
    chk("areset_stall", 32'(stall_count), 0);
    chk("areset_flush", 32'(flush_count), 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_reset_rdr", 32'(outs), 32'(O_RDR));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
